// File: rtl/layer_stream_feeder.sv
// Streams one activation vector onto the parallel A-bus, waits for the node tree
// to settle, snapshots every node output and streams the snapshot downstream.
module layer_stream_feeder #(
  parameter int N_IN   = 15,
  parameter int N_OUT  = 32,
  parameter int SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  output logic [N_IN*32-1:0]    a_bus,
  input  logic [N_OUT*32-1:0]   n_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err_len,
  input  logic                  err_clr
);

  // state     | meaning
  // S_LOAD    | accepting activation words into the A-bus slots
  // S_SETTLE  | A-bus frozen, settle down-counter running
  // S_CAPTURE | one cycle: snapshot all node outputs
  // S_DRAIN   | streaming the snapshot, one word per handshake
  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_CAPTURE, S_DRAIN} state_t;

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_IN - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(N_OUT - 1);

  state_t         state_q, state_d;
  logic [IW-1:0]  idx;
  logic [KW-1:0]  k;
  logic [CW-1:0]  cnt;
  logic [31:0]    a_mem [N_IN];
  logic [31:0]    obuf  [N_OUT];
  logic           in_hs, out_hs, vec_end, len_err;

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_LOAD);
  assign out_data  = obuf[k];
  assign out_last  = (state_q == S_DRAIN) && (k == K_LAST);

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign vec_end = in_hs && (in_last || (idx == IDX_LAST));
  // early in_last and a full vector without in_last are both length errors
  assign len_err = in_hs && (in_last != (idx == IDX_LAST));

  for (genvar i = 0; i < N_IN; i++) begin : g_abus
    assign a_bus[32*i +: 32] = a_mem[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:    if (vec_end) state_d = S_SETTLE;
      S_SETTLE:  if (cnt == '0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_DRAIN;
      S_DRAIN:   if (out_hs && (k == K_LAST)) state_d = S_LOAD;
      default:   state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      k       <= '0;
      cnt     <= '0;
      err_len <= 1'b0;
      for (int i = 0; i < N_IN; i++)  a_mem[i] <= '0;
      for (int j = 0; j < N_OUT; j++) obuf[j]  <= '0;
    end else begin
      if (len_err)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;

      if (in_hs) begin
        for (int i = 0; i < N_IN; i++) begin
          if (IW'(i) == idx)                  a_mem[i] <= in_data;
          else if (in_last && (IW'(i) > idx)) a_mem[i] <= '0;
        end
        idx <= vec_end ? '0 : idx + 1'b1;
      end

      if (vec_end)
        cnt <= CW'(SETTLE - 1);
      else if ((state_q == S_SETTLE) && (cnt != '0))
        cnt <= cnt - 1'b1;

      if (state_q == S_CAPTURE) begin
        for (int j = 0; j < N_OUT; j++) obuf[j] <= n_bus[32*j +: 32];
        k <= '0;
      end else if (out_hs) begin
        k <= (k == K_LAST) ? '0 : k + 1'b1;
      end
    end
  end

endmodule
